// File: rtl/axi_apb_pkg.sv
// Shared constants for the AXI-to-APB bridge: burst/response encodings,
// FSM state type and the field layout of the per-beat command payload.
package axi_apb_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    // Payload is {id, addr, strb, data, last}, last at bit 0.
    localparam int unsigned PL_LAST_LSB = 0;
    localparam int unsigned PL_DATA_LSB = 1;

    function automatic int unsigned pl_strb_lsb(input int unsigned data_w);
        return PL_DATA_LSB + data_w;
    endfunction

    function automatic int unsigned pl_addr_lsb(input int unsigned data_w);
        return pl_strb_lsb(data_w) + data_w / 8;
    endfunction

    function automatic int unsigned pl_id_lsb(input int unsigned addr_w, input int unsigned data_w);
        return pl_addr_lsb(data_w) + addr_w;
    endfunction

    function automatic int unsigned pl_width(input int unsigned id_w, input int unsigned addr_w,
                                             input int unsigned data_w);
        return pl_id_lsb(addr_w, data_w) + id_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head entry is visible on rd_data.
// Push while full is accepted only together with a pop.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_wr_burst_gen.sv
// AXI4 write front-end: buffers AW commands, expands bursts into per-beat
// {id, addr, strb, data, last} commands and returns in-order B responses.
module axi_wr_burst_gen
    import axi_apb_pkg::*;
#(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AW_DEPTH = 4,
    parameter int unsigned B_DEPTH  = 4
) (
    input  logic                                      ACLK_i,
    input  logic                                      ARESETn_i,
    input  logic [ID_W-1:0]                           AWID_i,
    input  logic [ADDR_W-1:0]                         AWADDR_i,
    input  logic [7:0]                                AWLEN_i,
    input  logic [2:0]                                AWSIZE_i,
    input  logic [1:0]                                AWBURST_i,
    input  logic                                      AWVALID_i,
    output logic                                      AWREADY_o,
    input  logic [DATA_W-1:0]                         WDATA_i,
    input  logic [DATA_W/8-1:0]                       WSTRB_i,
    input  logic                                      WLAST_i,
    input  logic                                      WVALID_i,
    output logic                                      WREADY_o,
    output logic [ID_W-1:0]                           BID_o,
    output logic [1:0]                                BRESP_o,
    output logic                                      BVALID_o,
    input  logic                                      BREADY_i,
    output logic                                      cmd_vld_o,
    input  logic                                      cmd_rdy_i,
    output logic [pl_width(ID_W, ADDR_W, DATA_W)-1:0] cmd_payload_o
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned SIZE_MAX = $clog2(STRB_W);
    localparam int unsigned AW_W     = ID_W + ADDR_W + 8 + 3 + 2;
    localparam int unsigned B_W      = ID_W + 2;

    logic                         rdy_en;
    logic                         aw_push, aw_pop, aw_full, aw_empty;
    logic [AW_W-1:0]              aw_head;
    logic [$clog2(AW_DEPTH):0]    aw_count;
    logic                         b_push, b_pop, b_full, b_empty;
    logic [B_W-1:0]               b_head;
    logic [$clog2(B_DEPTH):0]     b_count;

    logic [ID_W-1:0]   h_id;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_len;
    logic [2:0]        h_size;
    logic [1:0]        h_burst;
    logic              h_err;

    state_t            state;
    logic [ID_W-1:0]   c_id;
    logic [ADDR_W-1:0] c_start;
    logic [7:0]        c_len;
    logic [2:0]        c_size;
    logic [1:0]        c_burst;
    logic              c_err;
    logic [7:0]        beat_n;

    logic              in_burst, beat_is_end, stall, w_hs;
    logic [1:0]        resp;
    logic [ADDR_W-1:0] bytes, step, aligned, wrap_mask, wrap_lo, beat_addr;

    // AWREADY is held low for the first cycle out of reset.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) rdy_en <= 1'b0;
        else            rdy_en <= 1'b1;
    end

    assign AWREADY_o = rdy_en & ~aw_full;
    assign aw_push   = AWVALID_i & AWREADY_o;
    assign aw_pop    = (state == ST_IDLE) & ~aw_empty;

    sync_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AW_W)) u_aw_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .push    (aw_push),
        .wr_data ({AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i}),
        .pop     (aw_pop),
        .rd_data (aw_head),
        .full    (aw_full),
        .empty   (aw_empty),
        .count   (aw_count)
    );

    assign {h_id, h_addr, h_len, h_size, h_burst} = aw_head;

    always_comb begin
        h_err = 1'b0;
        if (h_size > 3'(SIZE_MAX)) h_err = 1'b1;
        if (h_burst == BURST_RSVD) h_err = 1'b1;
        if (h_burst == BURST_WRAP &&
            !(h_len == 8'd1 || h_len == 8'd3 || h_len == 8'd7 || h_len == 8'd15)) h_err = 1'b1;
    end

    // Beat forwarding; an end beat is held off while no B slot is free so
    // that the downstream never sees a beat the W channel has not accepted.
    assign in_burst    = (state == ST_BURST);
    assign beat_is_end = (beat_n == c_len) | WLAST_i;
    assign stall       = beat_is_end & b_full;
    assign WREADY_o    = in_burst & cmd_rdy_i & ~stall;
    assign cmd_vld_o   = in_burst & WVALID_i & ~stall;
    assign w_hs        = WVALID_i & WREADY_o;
    assign b_push      = w_hs & beat_is_end;
    assign resp        = (c_err | (WLAST_i & (beat_n != c_len)) | (~WLAST_i & (beat_n == c_len)))
                         ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        bytes     = ADDR_W'(1) << c_size;
        step      = ADDR_W'(beat_n) << c_size;
        aligned   = c_start & ~(bytes - ADDR_W'(1));
        wrap_mask = ((ADDR_W'(c_len) + ADDR_W'(1)) << c_size) - ADDR_W'(1);
        wrap_lo   = c_start & ~wrap_mask;
        beat_addr = c_start;
        case (c_burst)
            BURST_FIXED: beat_addr = c_start;
            BURST_WRAP:  beat_addr = wrap_lo + ((c_start - wrap_lo + step) & wrap_mask);
            default:     beat_addr = (beat_n == 8'd0) ? c_start : aligned + step;
        endcase
    end

    assign cmd_payload_o = {c_id, beat_addr, (c_err ? STRB_W'(0) : WSTRB_i), WDATA_i, beat_is_end};

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state   <= ST_IDLE;
            c_id    <= '0;
            c_start <= '0;
            c_len   <= '0;
            c_size  <= '0;
            c_burst <= '0;
            c_err   <= 1'b0;
            beat_n  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_pop) begin
                        c_id    <= h_id;
                        c_start <= h_addr;
                        c_len   <= h_len;
                        c_size  <= h_size;
                        c_burst <= h_burst;
                        c_err   <= h_err;
                        beat_n  <= '0;
                        state   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        if (beat_is_end) begin
                            beat_n <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            beat_n <= beat_n + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign b_pop    = BVALID_o & BREADY_i;
    assign BVALID_o = ~b_empty;
    assign {BID_o, BRESP_o} = b_head;

    sync_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) u_b_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .push    (b_push),
        .wr_data ({c_id, resp}),
        .pop     (b_pop),
        .rd_data (b_head),
        .full    (b_full),
        .empty   (b_empty),
        .count   (b_count)
    );

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Scoreboard bench for axi_wr_burst_gen: directed bursts push expected beats
// and B responses; a monitor pops and compares on every DUT handshake.
module tb_axi_wr_burst_gen;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PL_W   = ID_W + ADDR_W + STRB_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [7:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [STRB_W-1:0] wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic              cmd_vld;
    logic              cmd_rdy = 1'b1;
    logic [PL_W-1:0]   cmd_payload;

    logic [PL_W-1:0]   exp_cmd [$];
    logic [ID_W+1:0]   exp_b [$];
    int                n_checks = 0;
    int                n_pass = 0;
    bit                rnd_rdy = 1'b0;
    logic              bv;

    axi_wr_burst_gen #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AW_DEPTH(4), .B_DEPTH(4)) dut (
        .ACLK_i        (clk),
        .ARESETn_i     (rst_n),
        .AWID_i        (awid),
        .AWADDR_i      (awaddr),
        .AWLEN_i       (awlen),
        .AWSIZE_i      (awsize),
        .AWBURST_i     (awburst),
        .AWVALID_i     (awvalid),
        .AWREADY_o     (awready),
        .WDATA_i       (wdata),
        .WSTRB_i       (wstrb),
        .WLAST_i       (wlast),
        .WVALID_i      (wvalid),
        .WREADY_o      (wready),
        .BID_o         (bid),
        .BRESP_o       (bresp),
        .BVALID_o      (bvalid),
        .BREADY_i      (bready),
        .cmd_vld_o     (cmd_vld),
        .cmd_rdy_i     (cmd_rdy),
        .cmd_payload_o (cmd_payload)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_data(input logic [3:0] id, input int i);
        return {4'hD, id, 8'(i), 16'hBEEF};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare every beat and B handshake against the scoreboard.
    initial begin
        logic [PL_W-1:0] e;
        logic [ID_W+1:0] eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd_vld && cmd_rdy) begin
                    if (exp_cmd.size() == 0) begin
                        n_checks++;
                        $display("FAIL cmd_unexpected: got %0h expected none", cmd_payload);
                    end else begin
                        e = exp_cmd.pop_front();
                        chk("cmd_payload", 64'(cmd_payload), 64'(e));
                    end
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        n_checks++;
                        $display("FAIL b_unexpected: got id=%0h resp=%0h expected none", bid, bresp);
                    end else begin
                        eb = exp_b.pop_front();
                        chk("b_id_resp", 64'({bid, bresp}), 64'(eb));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) cmd_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic expect_burst(input logic [3:0] id, input logic [47:0] addrs, input logic [15:0] strbs,
                                input int nb, input logic err, input logic [1:0] resp);
        for (int i = 0; i < nb; i++) begin
            exp_cmd.push_back({id, addrs[i*12 +: 12], (err ? 4'h0 : strbs[i*4 +: 4]),
                               mk_data(id, i), 1'(i == nb - 1)});
        end
        exp_b.push_back({id, resp});
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!awready && t < 200);
        if (!awready) begin
            n_checks++;
            $display("FAIL aw_timeout: got awready=0 expected 1 for id %0h", id);
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input int i, input logic [3:0] strb, input logic last,
                          output logic bv_hs);
        int t = 0;
        wdata = mk_data(id, i); wstrb = strb; wlast = last; wvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!wready && t < 200);
        if (!wready) begin
            n_checks++;
            $display("FAIL w_timeout: got wready=0 expected 1 for id %0h beat %0d", id, i);
        end
        bv_hs = bvalid;
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [15:0] strbs, input int nb, input int last_at);
        logic b;
        for (int i = 0; i < nb; i++) begin
            w_beat(id, i, strbs[i*4 +: 4], 1'(i == last_at), b);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_b.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_cmd", 64'(exp_cmd.size()), 64'd0);
        chk("drain_b", 64'(exp_b.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_first_cycle", 64'(awready), 64'd0);
        @(negedge clk);
        chk("awready_second_cycle", 64'(awready), 64'd1);
        @(posedge clk);
        #1;

        // INCR 0x104, 4 beats, and B timing after the end beat
        expect_burst(4'h1, {12'h110, 12'h10C, 12'h108, 12'h104}, 16'hFFFF, 4, 1'b0, 2'b00);
        send_aw(4'h1, 12'h104, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++) w_beat(4'h1, i, 4'hF, 1'b0, bv);
        w_beat(4'h1, 3, 4'hF, 1'b1, bv);
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_at_end_hs", 64'(bv), 64'd0);
        @(negedge clk);
        chk("bvalid_next_cycle", 64'(bvalid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // WRAP 0x038, 4 x 4 bytes
        expect_burst(4'h2, {12'h034, 12'h030, 12'h03C, 12'h038}, 16'hFFFF, 4, 1'b0, 2'b00);
        send_aw(4'h2, 12'h038, 8'd3, 3'd2, 2'b10);
        send_w(4'h2, 16'hFFFF, 4, 3);
        drain();

        // FIXED 0x0FE, halfword beats with alternating strobes
        expect_burst(4'h3, {12'h000, 12'h0FE, 12'h0FE, 12'h0FE}, 16'h03C3, 3, 1'b0, 2'b00);
        send_aw(4'h3, 12'h0FE, 8'd2, 3'd1, 2'b00);
        send_w(4'h3, 16'h03C3, 3, 2);
        drain();

        // Oversized beat: strobes forced low, SLVERR
        expect_burst(4'h4, {12'h000, 12'h000, 12'h208, 12'h200}, 16'h00FF, 2, 1'b1, 2'b10);
        send_aw(4'h4, 12'h200, 8'd1, 3'd3, 2'b01);
        send_w(4'h4, 16'h00FF, 2, 1);
        drain();

        // Early WLAST then a clean burst
        expect_burst(4'h5, {12'h000, 12'h000, 12'h004, 12'h000}, 16'hFFFF, 2, 1'b0, 2'b10);
        send_aw(4'h5, 12'h000, 8'd3, 3'd2, 2'b01);
        send_w(4'h5, 16'hFFFF, 2, 1);
        expect_burst(4'h6, {12'h000, 12'h000, 12'h108, 12'h104}, 16'hA5A5, 2, 1'b0, 2'b00);
        send_aw(4'h6, 12'h104, 8'd1, 3'd2, 2'b01);
        send_w(4'h6, 16'hA5A5, 2, 1);
        drain();

        // Back-pressure: AW buffer fills, B buffer fills, end beat stalls
        bready = 1'b0;
        rnd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_burst(4'(7 + k), {36'h0, 12'(12'h300 + 4 * k)}, 16'h000F, 1, 1'b0, 2'b00);
        end
        expect_burst(4'hB, {12'h000, 12'h000, 12'h404, 12'h400}, 16'h00FF, 2, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            send_aw(4'(7 + k), 12'(12'h300 + 4 * k), 8'd0, 3'd2, 2'b01);
        end
        send_aw(4'hB, 12'h400, 8'd1, 3'd2, 2'b01);
        @(negedge clk);
        chk("awready_when_full", 64'(awready), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) send_w(4'(7 + k), 16'h000F, 1, 0);
        w_beat(4'hB, 0, 4'hF, 1'b0, bv);
        rnd_rdy = 1'b0;
        cmd_rdy = 1'b1;
        wdata = mk_data(4'hB, 1); wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wready_end_stall", 64'(wready), 64'd0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        w_beat(4'hB, 1, 4'hF, 1'b1, bv);
        wvalid = 1'b0; wlast = 1'b0;
        drain();

        // Reset in the middle of a burst
        expect_burst(4'hC, {12'h04C, 12'h048, 12'h044, 12'h040}, 16'hFFFF, 4, 1'b0, 2'b00);
        send_aw(4'hC, 12'h040, 8'd3, 3'd2, 2'b01);
        w_beat(4'hC, 0, 4'hF, 1'b0, bv);
        w_beat(4'hC, 1, 4'hF, 1'b0, bv);
        wdata = mk_data(4'hC, 2);
        rst_n = 1'b0;
        exp_cmd.delete();
        exp_b.delete();
        @(negedge clk);
        chk("midrst_awready", 64'(awready), 64'd0);
        chk("midrst_wready", 64'(wready), 64'd0);
        chk("midrst_cmd_vld", 64'(cmd_vld), 64'd0);
        chk("midrst_bvalid", 64'(bvalid), 64'd0);
        chk("midrst_bid_bresp", 64'({bid, bresp}), 64'd0);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast = 1'b0;
        rst_n = 1'b1;
        expect_burst(4'hD, {12'h000, 12'h000, 12'h084, 12'h080}, 16'hFFFF, 2, 1'b0, 2'b00);
        send_aw(4'hD, 12'h080, 8'd1, 3'd2, 2'b01);
        send_w(4'hD, 16'hFFFF, 2, 1);
        drain();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_gen.md
Name: axi_wr_burst_gen

Overview:
- Parameterised AXI4 write-channel front-end for the AXI-to-APB bridge.
- Buffers outstanding AW commands and expands each burst (FIXED/INCR/WRAP) into per-beat {id, addr, strb, data, last} commands for the downstream async FIFO.
- Checks WLAST and burst legality, and returns B responses in order, with buffering so that B back-pressure never blocks W traffic.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 12, byte address width (4 KB APB region).
- DATA_W, 32, W data width; legal values 32/64/128.
- AW_DEPTH, 4, AW command buffer entries, power of 2, >=2.
- B_DEPTH, 4, pending-B-response buffer entries, power of 2, >=2.

Ports:
- ACLK_i  in  1  clock.
- ARESETn_i  in  1  asynchronous active-low reset.
- AWID_i  in  ID_W  write ID.
- AWADDR_i  in  ADDR_W  start address.
- AWLEN_i  in  8  beats minus 1.
- AWSIZE_i  in  3  log2 of bytes per beat.
- AWBURST_i  in  2  00 FIXED, 01 INCR, 10 WRAP.
- AWVALID_i  in  1  AW valid.
- AWREADY_o  out  1  AW ready.
- WDATA_i  in  DATA_W  write data.
- WSTRB_i  in  DATA_W/8  byte strobes.
- WLAST_i  in  1  last beat.
- WVALID_i  in  1  W valid.
- WREADY_o  out  1  W ready.
- BID_o  out  ID_W  response ID.
- BRESP_o  out  2  00 OKAY, 10 SLVERR.
- BVALID_o  out  1  B valid.
- BREADY_i  in  1  B ready.
- cmd_vld_o  out  1  beat command valid.
- cmd_rdy_i  in  1  downstream ready.
- cmd_payload_o  out  ID_W+ADDR_W+DATA_W/8+DATA_W+1  {id, addr, strb, data, last}.

Behaviour:
- Reset: AWREADY_o=0, WREADY_o=0, BVALID_o=0, cmd_vld_o=0, BID_o=0, BRESP_o=0; FSM=IDLE; both buffers empty; beat counter=0. AWREADY_o rises 1 cycle after reset deassertion.
- Reset mid-burst: all buffered AW and B entries are discarded immediately. No partial command is replayed.
- AW buffer:
  - AWREADY_o = ~aw_full.
  - A push and a pop in the same cycle are both legal when full; the count is unchanged.
  - Entries are popped only in IDLE.
- FSM IDLE -> BURST: when the AW buffer is non-empty, pop the entry and register the burst context: id, start, len, size, burst, err.
  - err = 1 when AWSIZE_i > log2(DATA_W/8), when AWBURST_i = 11, or when WRAP has len+1 not in {2,4,8,16}.
  - The first beat can be accepted in the cycle after the pop. Minimum one idle cycle between bursts.
- BURST:
  - cmd_vld_o = WVALID_i.
  - WREADY_o = cmd_rdy_i & ~(beat_is_end & b_full).
  - W-to-cmd path is combinational: zero latency for data and strb.
- Beat address (beat counter n = 0..len), using bytes = 1<<size and aligned = start & ~(bytes-1):
  - FIXED: start.
  - INCR: n=0 gives start, otherwise aligned + n*bytes, modulo 2^ADDR_W.
  - WRAP: wrap_lo = start & ~(bytes*(len+1)-1). Address is wrap_lo + ((start - wrap_lo + n*bytes) mod (bytes*(len+1))).
- Strobe: cmd strb = WSTRB_i when err=0; forced to all zeros when err=1. Beats are still consumed and forwarded so that the W channel drains.
- Burst end:
  - beat_is_end = (n == len) | WLAST_i.
  - cmd last = beat_is_end.
  - On the end-beat handshake, push {id, resp} into the B buffer and return to IDLE.
  - resp = SLVERR if err, if WLAST_i was set with n<len, or if WLAST_i was clear at n==len. Otherwise resp = OKAY.
- B buffer:
  - BVALID_o = ~b_empty; BID_o/BRESP_o come from the head entry.
  - BVALID_o rises 1 cycle after the end-beat handshake.
  - Pop on BVALID_o & BREADY_i. Simultaneous push and pop when full is legal.
  - Responses are returned in AW order.
- No W data is accepted before its AW has been popped; WREADY_o=0 in IDLE.

Decomposition:
- Shared package axi_apb_pkg holds:
  - Burst constants FIXED/INCR/WRAP and resp constants OKAY/SLVERR.
  - Payload field-offset localparams, so the APB side can decode cmd_payload_o.
- Sub-module sync_fifo (params DEPTH, WIDTH; push/pop, full/empty, count) is instantiated twice: once for AW and once for B.
- Address generation stays inline.

Test Plan:
- INCR, AWADDR=0x104, LEN=3, SIZE=2, OKAY path: cmd addrs 0x104, 0x108, 0x10C, 0x110; last on beat 4; BRESP=00, BID matches, BVALID 1 cycle after the beat-4 handshake.
- WRAP, AWADDR=0x038, LEN=3, SIZE=2: addrs 0x038, 0x03C, 0x030, 0x034; BRESP=00.
- FIXED, AWADDR=0x0FE, LEN=2, SIZE=1, strb 0011/1100/0011: all three addrs 0x0FE; strb passes through unchanged.
- Errors:
  - SIZE=3 with DATA_W=32: all cmd strb=0000, BRESP=10.
  - INCR LEN=3 with WLAST on beat 2: burst ends after 2 beats, BRESP=10, and the next AW starts cleanly.
- Stress:
  - 4 AWs back-to-back with BREADY_i=0: AWREADY_o drops when the AW buffer is full.
  - WREADY_o stalls only on an end beat while the B buffer is full.
  - Releasing BREADY_i returns 4 responses in AW order.
  - cmd_rdy_i toggling randomly: no beat is lost or duplicated.
- Reset asserted mid-burst at beat 2: all outputs are 0 next cycle; after release, a fresh INCR burst completes with correct addresses and a single B.
